// File: rtl/rv32i_types_pkg.sv
// Shared RV32I types used across the core pipeline.
// Holds the fetch2->decode packet layout.
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic  token;
        word_t pc;
        word_t pc4;
        word_t instr;
        logic  prediction;
        logic  mal_insn;
        logic  fault_insn;
    } fetch_pkt_t;

endpackage

// File: rtl/ooo_fetch2_decode_q_if.sv
// Handshake bundle between fetch2 and decode around the instruction queue.
// fetch drives the enqueue side, decode drives the dequeue side.
interface ooo_fetch2_decode_q_if
    import rv32i_types_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic             enq_valid;
    logic             enq_ready;
    fetch_pkt_t       enq_pkt;
    logic             deq_valid;
    logic             deq_ready;
    fetch_pkt_t       deq_pkt;
    logic [CNT_W-1:0] count;

    modport fetch (
        output enq_valid,
        output enq_pkt,
        input  enq_ready
    );

    modport decode (
        input  deq_valid,
        input  deq_pkt,
        input  count,
        output deq_ready
    );
endinterface

// File: rtl/ooo_fetch2_decode_queue.sv
// Circular instruction queue between fetch2 and decode.
// Lets fetch run ahead of a stalled decode; flush empties it in one cycle.
module ooo_fetch2_decode_queue
    import rv32i_types_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  fetch_pkt_t       enq_pkt,
    output logic             deq_valid,
    input  logic             deq_ready,
    output fetch_pkt_t       deq_pkt,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    fetch_pkt_t       mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             enq_fire;
    logic             deq_fire;

    // Ready/valid come only from registered state, never from the other side.
    assign enq_ready = (count_q != CNT_W'(DEPTH));
    assign deq_valid = (count_q != '0);
    assign deq_pkt   = mem_q[head_q];
    assign count     = count_q;

    assign enq_fire = enq_valid && enq_ready && !flush;
    assign deq_fire = deq_valid && deq_ready && !flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) tail_d = tail_q + PTR_W'(1);
            if (deq_fire) head_d = head_q + PTR_W'(1);
            unique case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is left unreset; flush and reset only move pointers.
    always_ff @(posedge CLK) begin
        if (enq_fire) mem_q[tail_q] <= enq_pkt;
    end

endmodule

// File: tb/tb_ooo_fetch2_decode_queue.sv
// Self-checking bench for ooo_fetch2_decode_queue against a queue model.
// Directed steps followed by a randomized traffic phase.
module tb_ooo_fetch2_decode_queue;
    import rv32i_types_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             CLK = 1'b0;
    logic             nRST;
    logic             flush;
    logic             enq_valid;
    logic             enq_ready;
    fetch_pkt_t       enq_pkt;
    logic             deq_valid;
    logic             deq_ready;
    fetch_pkt_t       deq_pkt;
    logic [CNT_W-1:0] count;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_pkt_t model[$];

    ooo_fetch2_decode_queue #(.DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_pkt   (enq_pkt),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_pkt   (deq_pkt),
        .count     (count)
    );

    always #5 CLK = ~CLK;

    function automatic fetch_pkt_t mk(input word_t pc, input word_t instr,
                                      input logic pred, input logic mal,
                                      input logic flt, input logic tok);
        fetch_pkt_t p;
        p.token      = tok;
        p.pc         = pc;
        p.pc4        = pc + 32'd4;
        p.instr      = instr;
        p.prediction = pred;
        p.mal_insn   = mal;
        p.fault_insn = flt;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        int sz;
        sz = model.size();
        chk({tag, ":count"}, 128'(count), 128'(sz));
        chk({tag, ":enq_ready"}, 128'(enq_ready), 128'(sz != DEPTH));
        chk({tag, ":deq_valid"}, 128'(deq_valid), 128'(sz != 0));
        if (sz != 0) chk({tag, ":deq_pkt"}, 128'(deq_pkt), 128'(model[0]));
    endtask

    // Check outputs mid-cycle, clock once, then apply the model's rules.
    task automatic cycle(input string tag);
        bit ef, df;
        check_outs(tag);
        ef = enq_valid && (model.size() != DEPTH) && !flush;
        df = deq_ready && (model.size() != 0) && !flush;
        @(posedge CLK);
        if (flush) begin
            model.delete();
        end else begin
            if (df) void'(model.pop_front());
            if (ef) model.push_back(enq_pkt);
        end
        #1;
    endtask

    initial begin
        word_t exp_pc [4];
        nRST      = 1'b0;
        flush     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        enq_pkt   = '0;

        #2;
        chk("rst:count", 128'(count), 128'(0));
        chk("rst:enq_ready", 128'(enq_ready), 128'(1));
        chk("rst:deq_valid", 128'(deq_valid), 128'(0));
        #1 nRST = 1'b1;
        @(posedge CLK);
        #1;

        enq_valid = 1'b1;
        enq_pkt   = mk(32'h0000_0200, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("single_enq");
        enq_valid = 1'b0;
        chk("single:count", 128'(count), 128'(1));
        chk("single:pc", 128'(deq_pkt.pc), 128'(32'h200));
        chk("single:instr", 128'(deq_pkt.instr), 128'(32'h13));
        deq_ready = 1'b1;
        cycle("single_deq");
        deq_ready = 1'b0;
        chk("single:empty", 128'(deq_valid), 128'(0));

        for (int i = 0; i < 4; i++) begin
            exp_pc[i] = 32'h100 + 32'(4 * i);
            enq_valid = 1'b1;
            enq_pkt   = mk(exp_pc[i], 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            cycle("fill");
        end
        chk("full:count", 128'(count), 128'(4));
        chk("full:enq_ready", 128'(enq_ready), 128'(0));
        enq_pkt = mk(32'h110, 32'hdead, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("full_reject");
        chk("full:still4", 128'(count), 128'(4));
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain:pc", 128'(deq_pkt.pc), 128'(exp_pc[i]));
            cycle("drain");
        end
        deq_ready = 1'b0;

        enq_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            enq_pkt = mk(32'h300 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
            cycle("simul_pre");
        end
        deq_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            enq_pkt = mk(32'h308 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0,
                         1'($urandom));
            cycle("simul");
        end
        chk("simul:count2", 128'(count), 128'(2));

        enq_pkt = mk(32'h400, 32'h13, 1'b0, 1'b0, 1'b0, 1'b0);
        deq_ready = 1'b0;
        cycle("pre_flush");
        chk("flush:pre3", 128'(count), 128'(3));
        deq_ready = 1'b1;
        flush     = 1'b1;
        enq_pkt   = mk(32'hbad0, 32'hbad, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle("flush");
        flush     = 1'b0;
        enq_valid = 1'b0;
        chk("flush:count", 128'(count), 128'(0));
        chk("flush:deq_valid", 128'(deq_valid), 128'(0));
        chk("flush:enq_ready", 128'(enq_ready), 128'(1));
        cycle("post_flush");

        for (int i = 0; i < 12; i++) begin
            enq_valid = 1'b1;
            deq_ready = (i % 3) != 0;
            if (i % 2 == 0)
                enq_pkt = mk(32'h500 + 32'(4 * i), $urandom, 1'(i >> 1),
                             1'(i >> 2), 1'(i >> 1 ^ i >> 2), 1'b0);
            else
                enq_pkt = mk(32'h500 + 32'(4 * i), $urandom, 1'b0, 1'b0,
                             1'b0, 1'b0);
            cycle("fault");
        end
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cycle("fault_drain");

        for (int i = 0; i < 400; i++) begin
            enq_valid = 1'($urandom_range(0, 3) != 0);
            deq_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            enq_pkt   = mk($urandom, $urandom, 1'($urandom), 1'($urandom),
                           1'($urandom), 1'($urandom));
            cycle("rand");
        end
        flush     = 1'b0;
        deq_ready = 1'b0;
        enq_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            enq_pkt = mk(32'h600 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
            cycle("rand_fill");
        end
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        cycle("to3");
        deq_ready = 1'b0;
        enq_valid = 1'b0;
        chk("arst:pre3", 128'(count), 128'(3));

        nRST = 1'b0;
        #1;
        model.delete();
        chk("arst:count", 128'(count), 128'(0));
        chk("arst:deq_valid", 128'(deq_valid), 128'(0));
        chk("arst:enq_ready", 128'(enq_ready), 128'(1));
        #1 nRST = 1'b1;
        @(posedge CLK);
        #1;
        cycle("after_arst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
